timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 113 +++++++++++
 tb/tb_timer_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with interrupt (one window, T0 or T1).
// Optional TC_COUNT_WRITE_EN makes COUNT (offset 2) directly writable.
module timer_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic enable;
  logic auto_reload;

  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d    = preset_q;
        irq_flag_d = 1'b0;
        state_d    = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q == '0) begin
          state_d    = S_INT;
          irq_flag_d = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU writes are applied last so they override FSM updates in the same cycle.
    if (WE) begin
      case (Addr)
        2'd0: begin
          ctrl_d     = Din[3:0];
          irq_flag_d = 1'b0;
        end
        2'd1: preset_d = Din;
`ifdef TC_COUNT_WRITE_EN
        2'd2: count_d = Din;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      2'd0:    Dout = {28'd0, ctrl_q};
      2'd1:    Dout = preset_q;
      2'd2:    Dout = count_q;
      default: Dout = '0;
    endcase
  end

  assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed scoreboard bench for timer_counter: expected values are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_timer_counter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] exp_q[$];

  timer_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .IRQ     (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    push(e);
    Addr = a;
    #1;
    chk(tag, Dout);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    push({31'd0, e});
    chk(tag, {31'd0, IRQ});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
  endtask

  initial begin
    logic [31:0] cnt_exp;
    reset_n = 1'b0;
    Addr    = 2'd0;
    WE      = 1'b0;
    Din     = '0;

    // Reset state
    #2;
    for (int i = 0; i < 4; i++) chk_rd("reset_read", i[1:0], 32'd0);
    chk_irq("reset_irq", 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) chk_rd("post_reset_read", i[1:0], 32'd0);

    // Register access: upper CTRL bits, reserved offset, PRESET read-back
    wr(2'd0, 32'hFFFF_FFF0);
    chk_rd("ctrl_upper_ignored", 2'd0, 32'd0);
    wr(2'd3, 32'hDEAD_BEEF);
    chk_rd("offset3_reads0", 2'd3, 32'd0);
    wr(2'd1, 32'hA5A5_1234);
    chk_rd("preset_rb", 2'd1, 32'hA5A5_1234);

    // One-shot, PRESET=5: IRQ at E+8
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);                 // edge E
    tick(); tick();                  // E+2
    for (int k = 0; k < 6; k++) begin
      cnt_exp = 32'd5 - k;
      chk_rd("oneshot_count", 2'd2, cnt_exp);
      if (k < 5) tick();
    end
    chk_irq("oneshot_irq_E7", 1'b0);
    tick();                          // E+8
    chk_irq("oneshot_irq_E8", 1'b1);
    chk_rd("oneshot_count_int", 2'd2, 32'd0);
    tick();
    chk_rd("oneshot_ctrl_after", 2'd0, 32'h8);
    tick(); tick();
    chk_irq("oneshot_irq_held", 1'b1);
    wr(2'd0, 32'h8);
    chk_irq("oneshot_irq_cleared", 1'b0);

    // Auto-reload, PRESET=2: 2-cycle IRQ every 5 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);                 // edge E
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk_irq("autoreload_irq", (k >= 5) && (((k - 5) % 5) < 2));
      if (k >= 2 && k <= 4) chk_rd("autoreload_count", 2'd2, 32'(4 - k));
      if (k == 7) chk_rd("autoreload_reloaded", 2'd2, 32'd2);
    end
    wr(2'd0, 32'h0);
    tick(); tick();

    // Mid-count disable freezes COUNT, then re-enable reloads
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);                 // edge E
    for (int k = 0; k < 9; k++) tick();
    chk_rd("midcount_at3", 2'd2, 32'd3);
    wr(2'd0, 32'h8);
    chk_rd("midcount_after_wr", 2'd2, 32'd2);
    for (int k = 0; k < 5; k++) tick();
    chk_rd("midcount_frozen", 2'd2, 32'd2);
    chk_irq("midcount_no_irq", 1'b0);
    wr(2'd0, 32'h9);
    tick(); tick();
    chk_rd("reenable_reload", 2'd2, 32'd10);
    wr(2'd0, 32'h0);
    tick(); tick();

    // IM=0 one-shot expiry; later IM-only write must not raise IRQ
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);                 // edge E, INT at E+4
    for (int k = 0; k < 4; k++) tick();
    chk_irq("im0_expiry", 1'b0);
    tick();
    chk_rd("im0_enable_cleared", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk_irq("im0_then_im1", 1'b0);
    tick();
    chk_irq("im0_then_im1_later", 1'b0);

    // PRESET=0: INT at E+3; CTRL write during INT wins over Enable clear
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);                 // edge E
    tick(); tick();
    chk_irq("preset0_E2", 1'b0);
    tick();
    chk_irq("preset0_E3", 1'b1);
    wr(2'd0, 32'h9);                 // collides with INT
    chk_rd("collision_ctrl", 2'd0, 32'h9);
    chk_irq("collision_irq", 1'b0);
    wr(2'd0, 32'h0);
    tick(); tick();

    // COUNT write during CNT
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);                 // edge E
    for (int k = 0; k < 4; k++) tick();
    chk_rd("cntwr_before", 2'd2, 32'd98);
    wr(2'd2, 32'd1);                 // edge E+5
`ifdef TC_COUNT_WRITE_EN
    chk_rd("cntwr_loaded", 2'd2, 32'd1);
    tick(); tick();
    chk_irq("cntwr_irq", 1'b1);
`else
    chk_rd("cntwr_ignored", 2'd2, 32'd97);
    tick(); tick();
    chk_rd("cntwr_continues", 2'd2, 32'd95);
    chk_irq("cntwr_irq", 1'b0);
`endif
    wr(2'd0, 32'h0);
    tick(); tick();

    // Asynchronous reset mid-count
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 5; k++) tick();
    reset_n = 1'b0;
    #1;
    chk_rd("async_reset_count", 2'd2, 32'd0);
    chk_rd("async_reset_ctrl", 2'd0, 32'd0);
    chk_rd("async_reset_preset", 2'd1, 32'd0);
    chk_irq("async_reset_irq", 1'b0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 60; k++) tick();
    chk_irq("post_reset_no_irq", 1'b0);
    chk_rd("post_reset_count", 2'd2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
